tetris_input_ctrl: RTL and testbench

Upstream front-end for the Tetris game FSM. It conditions the raw push-buttons (synchronise, debounce, edge-detect, left/right auto-repeat) and generates the gravity tick `onehuzz`, whose period shrinks as score rises. It latches each button request until the game FSM samples it on the next tick rising edge, so the game FSM (clocked by the tick) never misses a press made between ticks.

---
 rtl/tetris_pkg.sv | 41 ++++
 rtl/btn_conditioner.sv | 44 ++++
 rtl/tetris_input_ctrl.sv | 144 ++++++++++++++
 tb/tb_tetris_input_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared Tetris timing defaults, level constants and the speed-curve helpers
// used by the input front-end, the game FSM and the score display.
package tetris_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 250000;
  localparam int unsigned REPEAT_DELAY_DEF    = 4000000;
  localparam int unsigned REPEAT_RATE_DEF     = 2000000;
  localparam int unsigned TICK_BASE_DEF       = 25000000;
  localparam int unsigned TICK_STEP_DEF       = 2000000;
  localparam int unsigned TICK_MIN_DEF        = 5000000;

  localparam int LEVEL_W = 4;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

  typedef struct packed {
    logic left;
    logic right;
    logic rotate;
    logic start;
  } btn_req_t;

  function automatic logic [LEVEL_W-1:0] score_to_level(input logic [7:0] score);
    logic [4:0] raw_level;
    raw_level = score[7:3];
    if (raw_level > 5'(LEVEL_MAX)) return LEVEL_MAX;
    return raw_level[LEVEL_W-1:0];
  endfunction

  // Any subtraction that would underflow or dip below the floor yields min_p.
  function automatic logic [31:0] tick_period(input logic [LEVEL_W-1:0] level,
                                              input logic [31:0] base,
                                              input logic [31:0] step,
                                              input logic [31:0] min_p);
    logic [31:0] dec;
    dec = 32'(level) * step;
    if (dec >= base) return min_p;
    if ((base - dec) < min_p) return min_p;
    return base - dec;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One push-button path: 2-FF synchroniser, debounce counter and a one-cycle
// press pulse on each debounced rising edge.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic debounced,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             debounced_q;

  // The counter only runs while the synced input disagrees with the debounced
  // state, so any bounce back to agreement restarts the qualification window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync        <= '0;
      cnt         <= '0;
      debounced   <= 1'b0;
      debounced_q <= 1'b0;
      press       <= 1'b0;
    end else begin
      sync        <= {sync[0], btn_raw};
      debounced_q <= debounced;
      press       <= debounced & ~debounced_q;
      if (sync[1] == debounced) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        debounced <= ~debounced;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tetris_input_ctrl.sv
// Tetris input front-end: conditioned buttons with left/right auto-repeat,
// per-tick request latches, score-driven level and the gravity tick onehuzz.
module tetris_input_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_RATE     = REPEAT_RATE_DEF,
  parameter int unsigned TICK_BASE       = TICK_BASE_DEF,
  parameter int unsigned TICK_STEP       = TICK_STEP_DEF,
  parameter int unsigned TICK_MIN        = TICK_MIN_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_left_raw,
  input  logic               btn_right_raw,
  input  logic               btn_rotate_raw,
  input  logic               btn_start_raw,
  input  logic [7:0]         score,
  input  logic               gameover,
  output logic               onehuzz,
  output logic               left_o,
  output logic               right_o,
  output logic               rotate_o,
  output logic               start_o,
  output logic [LEVEL_W-1:0] level_o
);

  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_RATE);

  logic left_deb, right_deb, rotate_deb, start_deb;
  logic left_press, right_press, rotate_press, start_press;
  logic unused_deb;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk(clk), .reset(reset), .btn_raw(btn_left_raw),
    .debounced(left_deb), .press(left_press)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk(clk), .reset(reset), .btn_raw(btn_right_raw),
    .debounced(right_deb), .press(right_press)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rotate (
    .clk(clk), .reset(reset), .btn_raw(btn_rotate_raw),
    .debounced(rotate_deb), .press(rotate_press)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk(clk), .reset(reset), .btn_raw(btn_start_raw),
    .debounced(start_deb), .press(start_press)
  );

  assign unused_deb = rotate_deb ^ start_deb;

  logic [1:0]       lr_deb;
  logic [1:0]       rep_first;
  logic [1:0]       rep_pulse;
  logic [REP_W-1:0] hold_cnt [2];

  assign lr_deb = {right_deb, left_deb};

  // Index 0 is left, 1 is right. The counter starts the cycle the debounced
  // level rises, which lands the first repeat REPEAT_DELAY after the press pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_first <= 2'b11;
      rep_pulse <= 2'b00;
      for (int i = 0; i < 2; i++) hold_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rep_pulse[i] <= 1'b0;
        if (!lr_deb[i]) begin
          hold_cnt[i]  <= '0;
          rep_first[i] <= 1'b1;
        end else if (hold_cnt[i] == (rep_first[i] ? REP_FIRST : REP_NEXT)) begin
          rep_pulse[i] <= 1'b1;
          hold_cnt[i]  <= REP_W'(1);
          rep_first[i] <= 1'b0;
        end else begin
          hold_cnt[i] <= hold_cnt[i] + REP_W'(1);
        end
      end
    end
  end

  logic     left_evt, right_evt, tick_rise, onehuzz_q;
  btn_req_t req_q, req_d;

  // New events override the post-sample clear so a press on that edge is kept.
  always_comb begin
    left_evt  = left_press | rep_pulse[0];
    right_evt = right_press | rep_pulse[1];
    tick_rise = onehuzz & ~onehuzz_q;
    req_d     = req_q;
    if (tick_rise) req_d = '0;
    if (left_evt) begin
      req_d.left  = 1'b1;
      req_d.right = 1'b0;
    end else if (right_evt) begin
      req_d.right = 1'b1;
      req_d.left  = 1'b0;
    end
    if (rotate_press) req_d.rotate = 1'b1;
    if (start_press) req_d.start = 1'b1;
    if (gameover) begin
      req_d.left   = 1'b0;
      req_d.right  = 1'b0;
      req_d.rotate = 1'b0;
    end
  end

  logic [31:0] half_cnt, half_len;

  // The half-period is only reloaded on a toggle, so level changes never cut a phase short.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      onehuzz   <= 1'b0;
      onehuzz_q <= 1'b0;
      half_cnt  <= '0;
      half_len  <= 32'(TICK_BASE / 2);
      level_o   <= '0;
      req_q     <= '0;
    end else begin
      level_o   <= score_to_level(score);
      onehuzz_q <= onehuzz;
      req_q     <= req_d;
      if (half_cnt == half_len - 32'd1) begin
        onehuzz  <= ~onehuzz;
        half_cnt <= '0;
        half_len <= tick_period(level_o, 32'(TICK_BASE), 32'(TICK_STEP), 32'(TICK_MIN)) >> 1;
      end else begin
        half_cnt <= half_cnt + 32'd1;
      end
    end
  end

  assign left_o   = req_q.left;
  assign right_o  = req_q.right;
  assign rotate_o = req_q.rotate;
  assign start_o  = req_q.start;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Scoreboard bench for tetris_input_ctrl: a planned random/directed stimulus
// timeline, a rule-level reference model and a separate output monitor.
module tb_tetris_input_ctrl;

  localparam int D       = 4;
  localparam int RD      = 20;
  localparam int RR      = 10;
  localparam int T_BASE  = 40;
  localparam int T_STEP  = 4;
  localparam int T_MIN   = 8;
  localparam int NCYC    = 4000;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_left_raw, btn_right_raw, btn_rotate_raw, btn_start_raw;
  logic [7:0] score;
  logic       gameover;
  logic       onehuzz, left_o, right_o, rotate_o, start_o;
  logic [3:0] level_o;

  always #5 clk = ~clk;

  tetris_input_ctrl #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
    .TICK_BASE(T_BASE), .TICK_STEP(T_STEP), .TICK_MIN(T_MIN)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_left_raw(btn_left_raw), .btn_right_raw(btn_right_raw),
    .btn_rotate_raw(btn_rotate_raw), .btn_start_raw(btn_start_raw),
    .score(score), .gameover(gameover), .onehuzz(onehuzz),
    .left_o(left_o), .right_o(right_o), .rotate_o(rotate_o), .start_o(start_o),
    .level_o(level_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus timeline, indexed by cycle; button index 0..3 = left, right, rotate, start.
  bit         raw_plan [4][NCYC+1];
  bit         ev       [4][NCYC+300];
  logic [7:0] score_plan [NCYC+1];
  bit         go_plan    [NCYC+1];

  int         phase_q[$];
  logic [3:0] req_q[$];
  logic [3:0] post_q[$];

  int cyc = 0;
  bit run = 1'b0;
  int model_toggles = 0;
  int dut_toggles = 0;

  task automatic checkOutput(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int refLevel(input int s);
    return (s / 8 > 15) ? 15 : s / 8;
  endfunction

  function automatic int refPeriod(input int lvl);
    int p;
    p = T_BASE - lvl * T_STEP;
    return (p < T_MIN) ? T_MIN : p;
  endfunction

  task automatic addPress(input int b, input int r, input int hold);
    for (int c = r; c < r + hold && c <= NCYC; c++) raw_plan[b][c] = 1'b1;
  endtask

  // Requests as the game FSM sees them after processing event cycles a..b
  // from an empty state; bit order {left, right, rotate, start}.
  function automatic logic [3:0] windowReq(input int a, input int b);
    logic [3:0] s;
    s = 4'b0000;
    for (int c = a; c <= b; c++) begin
      if (ev[0][c]) begin
        s[3] = 1'b1; s[2] = 1'b0;
      end else if (ev[1][c]) begin
        s[2] = 1'b1; s[3] = 1'b0;
      end
      if (ev[2][c]) s[1] = 1'b1;
      if (ev[3][c]) s[0] = 1'b1;
      if (go_plan[c]) s[3:1] = 3'b000;
    end
    return s;
  endfunction

  task automatic buildPlan();
    int pos, hold, val, len;
    for (int c = 0; c <= NCYC; c++) begin
      score_plan[c] = 8'd0;
      go_plan[c] = 1'b0;
      for (int b = 0; b < 4; b++) raw_plan[b][c] = 1'b0;
    end
    addPress(0, 5, 3);
    addPress(0, 20, 10);
    addPress(1, 100, 60);
    addPress(0, 200, 10);
    addPress(1, 200, 10);
    addPress(1, 250, 10);
    addPress(0, 253, 10);
    for (int c = 300; c < 450; c++) score_plan[c] = 8'd16;
    for (int c = 450; c < 550; c++) score_plan[c] = 8'd255;
    for (int c = 600; c < 820; c++) go_plan[c] = 1'b1;
    addPress(0, 620, 8);
    addPress(2, 650, 8);
    addPress(3, 700, 8);
    for (int b = 0; b < 4; b++) begin
      pos = 900 + int'($urandom_range(0, 30));
      while (pos < NCYC - 200) begin
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, D - 1))
                                           : int'($urandom_range(D, 70));
        addPress(b, pos, hold);
        pos = pos + hold + int'($urandom_range(D, 60));
      end
    end
    pos = 900;
    while (pos <= NCYC) begin
      val = int'($urandom_range(0, 255));
      len = int'($urandom_range(40, 300));
      for (int c = pos; c < pos + len && c <= NCYC; c++) score_plan[c] = 8'(val);
      pos = pos + len;
    end
    for (int c = 2500; c < 2650; c++) go_plan[c] = 1'b1;
  endtask

  // A qualified hold yields a press D+3 cycles after the raw rise; left/right
  // repeats continue while the debounced level is still high one cycle earlier.
  task automatic buildEvents();
    int f, t, e;
    for (int b = 0; b < 4; b++)
      for (int c = 0; c < NCYC + 300; c++) ev[b][c] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int r = 0; r <= NCYC; r++) begin
        if (raw_plan[b][r] && (r == 0 || !raw_plan[b][r-1])) begin
          f = r;
          while (f <= NCYC && raw_plan[b][f]) f++;
          if (f - r >= D) begin
            t = r + D + 3;
            ev[b][t] = 1'b1;
            if (b < 2) begin
              e = t + RD;
              while (e <= f + 2 + D) begin
                ev[b][e] = 1'b1;
                e = e + RR;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input int c);
    btn_left_raw   = raw_plan[0][c];
    btn_right_raw  = raw_plan[1][c];
    btn_rotate_raw = raw_plan[2][c];
    btn_start_raw  = raw_plan[3][c];
    score          = score_plan[c];
    gameover       = go_plan[c];
  endtask

  int next_toggle = T_BASE / 2;
  int phase_start = 0;
  int eprev = 0;
  bit m_tick = 1'b0;

  task automatic modelStep(input int c);
    int half;
    if (c == next_toggle) begin
      phase_q.push_back(c - phase_start);
      model_toggles++;
      half = refPeriod(refLevel(int'(score_plan[c-2]))) / 2;
      phase_start = c;
      next_toggle = c + half;
      m_tick = !m_tick;
      if (m_tick) begin
        req_q.push_back(windowReq(eprev, c - 1));
        post_q.push_back(windowReq(c, c));
        eprev = c;
      end
    end
  endtask

  // Monitor: compares at every observed tick edge, independent of the driver.
  initial begin : monitor
    bit         prev_tick;
    int         last_toggle;
    bit         post_pending;
    logic [3:0] post_exp;
    logic [3:0] dut_vec;
    prev_tick = 1'b0;
    last_toggle = 0;
    post_pending = 1'b0;
    post_exp = 4'b0;
    forever begin
      @(negedge clk);
      if (!run) continue;
      dut_vec = {left_o, right_o, rotate_o, start_o};
      if (post_pending) begin
        checkOutput("req_after_clear", int'(dut_vec), int'(post_exp));
        post_pending = 1'b0;
      end
      if (onehuzz !== prev_tick) begin
        dut_toggles++;
        checkOutput("level", int'(level_o), refLevel(int'(score_plan[cyc-1])));
        if (phase_q.size() == 0) begin
          checkOutput("phase_q_empty", 1, 0);
        end else begin
          checkOutput("phase_len", cyc - last_toggle, phase_q.pop_front());
        end
        if (onehuzz === 1'b1) begin
          if (req_q.size() == 0 || post_q.size() == 0) begin
            checkOutput("req_q_empty", 1, 0);
          end else begin
            checkOutput("req_at_rise", int'(dut_vec), int'(req_q.pop_front()));
            post_exp = post_q.pop_front();
            post_pending = 1'b1;
          end
        end
        prev_tick = onehuzz;
        last_toggle = cyc;
      end else if (cyc - last_toggle > 200) begin
        checkOutput("tick_timeout", cyc - last_toggle, 0);
        last_toggle = cyc;
      end
    end
  end

  initial begin : driver
    int n;
    buildPlan();
    buildEvents();
    reset = 1'b1;
    applyStimulus(0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs",
                int'({onehuzz, left_o, right_o, rotate_o, start_o, level_o}), 0);
    reset = 1'b0;
    n = 0;
    while (onehuzz == 1'b0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("first_low_phase", n, T_BASE / 2);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("mid_high_level", int'(onehuzz), 1);
    reset = 1'b1;
    #1;
    checkOutput("reset_mid_high", int'(onehuzz), 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_held_requests", int'({left_o, right_o, rotate_o, start_o}), 0);
    reset = 1'b0;
    cyc = 0;
    applyStimulus(0);
    run = 1'b1;
    for (int c = 1; c <= NCYC; c++) begin
      @(posedge clk);
      cyc = c;
      modelStep(c);
      #1;
      applyStimulus(c);
    end
    @(negedge clk);
    #1;
    run = 1'b0;
    checkOutput("toggle_count", dut_toggles, model_toggles);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
